// File: rtl/cdc_update_pusher.sv
// Source-domain producer for the feedback CDC sync: mirrors cfg_data across the
// write/ready handshake on change, force or refresh, coalescing updates made mid-transfer.
module cdc_update_pusher #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned REFRESH_PERIOD = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_force,
    output logic [WIDTH-1:0] sync_data,
    output logic             sync_write,
    input  logic             sync_ready,
    output logic             pending,
    output logic             busy,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] coalesced_cnt
);

    localparam int unsigned HoldEff = (HOLDOFF_CYCLES == 0) ? 1 : HOLDOFF_CYCLES;
    localparam int unsigned HoldW   = $clog2(HoldEff + 1);
    localparam int unsigned RefEff  = (REFRESH_PERIOD == 0) ? 1 : REFRESH_PERIOD;
    localparam int unsigned RefW    = $clog2(RefEff + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldEff - 1);
    localparam logic [RefW-1:0]  RefLast  = RefW'(RefEff - 1);

    typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] sync_data_q, sync_data_d;
    logic [WIDTH-1:0] cfg_data_q;
    logic             force_pending_q, force_pending_d;
    logic             refresh_due_q, refresh_due_d;
    logic             pending_q;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RefW-1:0]  ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0] coalesced_cnt_q, coalesced_cnt_d;

    logic dirty, trigger, launch, xfer, hold_done;

    assign dirty     = (cfg_data != sync_data_q);
    assign trigger   = dirty | force_pending_q | cfg_force | refresh_due_q;
    assign launch    = (state_q == StIdle) & trigger;
    assign xfer      = sync_write & sync_ready;
    assign hold_done = (hold_cnt_q == HoldLast);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (trigger) state_d = StSend;
            StSend: if (sync_ready) state_d = StHold;
            StHold: if (hold_done && sync_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state only, so reset drops sync_write immediately
    always_comb begin
        sync_write = (state_q == StSend);
        busy       = (state_q != StIdle);
    end

    always_comb begin
        sync_data_d     = sync_data_q;
        force_pending_d = force_pending_q;
        refresh_due_d   = refresh_due_q;
        hold_cnt_d      = hold_cnt_q;
        ref_cnt_d       = ref_cnt_q;
        sent_cnt_d      = sent_cnt_q;
        coalesced_cnt_d = coalesced_cnt_q;

        if (state_q != StIdle && cfg_force) begin
            force_pending_d = 1'b1;
        end

        // Not armed in SEND: the counter clears on that transfer anyway
        if (REFRESH_PERIOD != 0) begin
            if (xfer) begin
                ref_cnt_d = '0;
            end else if (ref_cnt_q != RefLast) begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
            if (ref_cnt_q == RefLast && state_q != StSend) begin
                refresh_due_d = 1'b1;
            end
        end

        if (launch) begin
            sync_data_d     = cfg_data;
            force_pending_d = 1'b0;
            refresh_due_d   = 1'b0;
        end

        if (xfer) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
            hold_cnt_d = '0;
        end else if (state_q == StHold && !hold_done) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        if (state_q != StIdle && cfg_data != cfg_data_q) begin
            coalesced_cnt_d = coalesced_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_data_q     <= '0;
            cfg_data_q      <= '0;
            force_pending_q <= 1'b0;
            refresh_due_q   <= 1'b0;
            pending_q       <= 1'b0;
            hold_cnt_q      <= '0;
            ref_cnt_q       <= '0;
            sent_cnt_q      <= '0;
            coalesced_cnt_q <= '0;
        end else begin
            sync_data_q     <= sync_data_d;
            cfg_data_q      <= cfg_data;
            force_pending_q <= force_pending_d;
            refresh_due_q   <= refresh_due_d;
            pending_q       <= trigger;
            hold_cnt_q      <= hold_cnt_d;
            ref_cnt_q       <= ref_cnt_d;
            sent_cnt_q      <= sent_cnt_d;
            coalesced_cnt_q <= coalesced_cnt_d;
        end
    end

    assign sync_data     = sync_data_q;
    assign pending       = pending_q;
    assign sent_cnt      = sent_cnt_q;
    assign coalesced_cnt = coalesced_cnt_q;

endmodule

// File: tb/tb_cdc_update_pusher.sv
// Self-checking bench for cdc_update_pusher: scenario tasks plus a transfer scoreboard.
module tb_cdc_update_pusher;

    localparam int unsigned Hold   = 4;
    localparam int unsigned RefPer = 20;

    logic        clk;
    logic        rst_n;
    logic [31:0] cfg_data;
    logic        cfg_force;
    logic [31:0] sync_data;
    logic        sync_write;
    logic        sync_ready;
    logic        pending;
    logic        busy;
    logic [15:0] sent_cnt;
    logic [15:0] coalesced_cnt;

    logic [31:0] r_cfg;
    logic        r_force;
    logic        r_ready;
    logic [31:0] r_sync_data;
    logic        r_sync_write;
    logic        r_pending;
    logic        r_busy;
    logic [15:0] r_sent_cnt;
    logic [15:0] r_coalesced_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          xfer_count = 0;
    int          cyc = 0;
    int unsigned exp_sent = 0;
    int unsigned exp_coal = 0;
    logic [31:0] exp_q[$];
    int          r_times[$];
    logic [31:0] r_vals[$];

    cdc_update_pusher #(
        .WIDTH(32), .HOLDOFF_CYCLES(Hold), .REFRESH_PERIOD(0), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_force(cfg_force),
        .sync_data(sync_data), .sync_write(sync_write), .sync_ready(sync_ready),
        .pending(pending), .busy(busy), .sent_cnt(sent_cnt), .coalesced_cnt(coalesced_cnt)
    );

    cdc_update_pusher #(
        .WIDTH(32), .HOLDOFF_CYCLES(Hold), .REFRESH_PERIOD(RefPer), .CNT_W(16)
    ) dut_ref (
        .clk(clk), .rst_n(rst_n), .cfg_data(r_cfg), .cfg_force(r_force),
        .sync_data(r_sync_data), .sync_write(r_sync_write), .sync_ready(r_ready),
        .pending(r_pending), .busy(r_busy), .sent_cnt(r_sent_cnt),
        .coalesced_cnt(r_coalesced_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every transfer must match the oldest expected value
    always @(negedge clk) begin
        if (rst_n && sync_write && sync_ready) begin
            xfer_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL xfer_unexpected: got %h, required no transfer", sync_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (sync_data !== e) begin
                    n_err++;
                    $display("FAIL xfer_data: got %h, required %h", sync_data, e);
                end
            end
        end
        if (rst_n && r_sync_write && r_ready) begin
            r_times.push_back(cyc);
            r_vals.push_back(r_sync_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && !pending && !sync_write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_data = '0; cfg_force = 1'b0; sync_ready = 1'b1;
        r_cfg = 32'h42; r_force = 1'b0; r_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({sync_write, busy, pending} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 000", {sync_write, busy, pending});
        end
        n_cmp++;
        if (sent_cnt !== 16'd0 || coalesced_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d/%0d, required 0/0", sent_cnt, coalesced_cnt);
        end
        n_cmp++;
        if (sync_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h, required 0", sync_data);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (xfer_count !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_zero_idle: got xfers=%0d busy=%b, required 0/0", xfer_count, busy);
        end
    endtask

    task automatic test_latency();
        int base;
        base = xfer_count;
        cfg_data = 32'hA5A5_0001;
        exp_q.push_back(cfg_data);
        tick();
        n_cmp++;
        if (sync_write !== 1'b1 || sync_data !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL lat_send: got w=%b d=%h, required 1/a5a50001", sync_write, sync_data);
        end
        tick();
        exp_sent++;
        n_cmp++;
        if (sync_write !== 1'b0 || xfer_count !== base + 1) begin
            n_err++;
            $display("FAIL lat_pulse: got w=%b xfers=%0d, required 0/%0d",
                     sync_write, xfer_count - base, 1);
        end
        n_cmp++;
        if (sent_cnt !== 16'(exp_sent) || pending !== 1'b0) begin
            n_err++;
            $display("FAIL lat_cnt: got sent=%0d pend=%b, required %0d/0", sent_cnt, pending, exp_sent);
        end
        repeat (Hold - 1) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL lat_hold: got busy=%b, required 1", busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL lat_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_coalesce();
        bit ok;
        int base;
        base = xfer_count;
        cfg_data = 32'h11;
        exp_q.push_back(cfg_data);
        tick();
        tick();
        sync_ready = 1'b0;
        cfg_data = 32'd1;
        tick();
        cfg_data = 32'd2;
        tick();
        cfg_data = 32'd3;
        exp_q.push_back(cfg_data);
        exp_coal += 3;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (sync_write !== 1'b0) begin
                n_err++;
                $display("FAIL coal_stall_write: cycle %0d got 1, required 0", i);
            end
        end
        sync_ready = 1'b1;
        wait_quiet(ok);
        exp_sent += 2;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL coal_timeout: got busy, required idle");
        end
        n_cmp++;
        if (xfer_count !== base + 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL coal_xfers: got %0d left=%0d, required 2/0", xfer_count - base, exp_q.size());
        end
        n_cmp++;
        if (coalesced_cnt !== 16'(exp_coal) || sent_cnt !== 16'(exp_sent)) begin
            n_err++;
            $display("FAIL coal_cnt: got coal=%0d sent=%0d, required %0d/%0d",
                     coalesced_cnt, sent_cnt, exp_coal, exp_sent);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int base;
        base = xfer_count;
        sync_ready = 1'b0;
        cfg_data = 32'h5555_AAAA;
        exp_q.push_back(cfg_data);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (sync_write !== 1'b1 || sync_data !== 32'h5555_AAAA) begin
                n_err++;
                $display("FAIL stall_stable: cycle %0d got w=%b d=%h, required 1/5555aaaa",
                         i, sync_write, sync_data);
            end
            tick();
        end
        n_cmp++;
        if (xfer_count !== base || sync_write !== 1'b1) begin
            n_err++;
            $display("FAIL stall_noxfer: got xfers=%0d w=%b, required 0/1", xfer_count - base, sync_write);
        end
        sync_ready = 1'b1;
        tick();
        exp_sent++;
        n_cmp++;
        if (xfer_count !== base + 1 || sync_write !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got xfers=%0d w=%b, required 1/0", xfer_count - base, sync_write);
        end
        wait_quiet(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0 || sent_cnt !== 16'(exp_sent)) begin
            n_err++;
            $display("FAIL stall_end: got ok=%b left=%0d sent=%0d, required 1/0/%0d",
                     ok, exp_q.size(), sent_cnt, exp_sent);
        end
    endtask

    task automatic test_force();
        bit ok;
        int base;
        base = xfer_count;
        cfg_force = 1'b1;
        exp_q.push_back(cfg_data);
        tick();
        cfg_force = 1'b0;
        tick();
        cfg_force = 1'b1;
        exp_q.push_back(cfg_data);
        tick();
        cfg_force = 1'b0;
        wait_quiet(ok);
        repeat (5) tick();
        exp_sent += 2;
        n_cmp++;
        if (!ok || xfer_count !== base + 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL force_xfers: got ok=%b xfers=%0d left=%0d, required 1/2/0",
                     ok, xfer_count - base, exp_q.size());
        end
        n_cmp++;
        if (sent_cnt !== 16'(exp_sent)) begin
            n_err++;
            $display("FAIL force_cnt: got %0d, required %0d", sent_cnt, exp_sent);
        end
    endtask

    task automatic test_refresh();
        int base;
        base = xfer_count;
        r_times.delete();
        r_vals.delete();
        repeat (130) tick();
        n_cmp++;
        if (xfer_count !== base) begin
            n_err++;
            $display("FAIL refresh_off: got %0d transfers, required 0", xfer_count - base);
        end
        n_cmp++;
        if (r_times.size() < 5) begin
            n_err++;
            $display("FAIL refresh_count: got %0d transfers, required >=5", r_times.size());
        end
        for (int i = 1; i < r_times.size(); i++) begin
            int gap;
            gap = r_times[i] - r_times[i-1];
            n_cmp++;
            if (gap < int'(RefPer) || gap > int'(RefPer + Hold + 2)) begin
                n_err++;
                $display("FAIL refresh_gap: got %0d cycles, required %0d..%0d",
                         gap, RefPer, RefPer + Hold + 2);
            end
        end
        foreach (r_vals[i]) begin
            n_cmp++;
            if (r_vals[i] !== 32'h42) begin
                n_err++;
                $display("FAIL refresh_data: got %h, required 00000042", r_vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        sync_ready = 1'b0;
        cfg_data = 32'h77;
        tick();
        n_cmp++;
        if (sync_write !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_send: got w=%b, required 1", sync_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_sent = 0;
        exp_coal = 0;
        n_cmp++;
        if (sync_write !== 1'b0 || pending !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got w=%b p=%b b=%b, required 0/0/0", sync_write, pending, busy);
        end
        n_cmp++;
        if (sent_cnt !== 16'd0 || coalesced_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rstmid_cnt: got %0d/%0d, required 0/0", sent_cnt, coalesced_cnt);
        end
        cfg_data = '0;
        sync_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = xfer_count;
        repeat (10) tick();
        n_cmp++;
        if (xfer_count !== base || busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_quiet: got xfers=%0d busy=%b left=%0d, required 0/0/0",
                     xfer_count - base, busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_coalesce();
        test_stall();
        test_force();
        test_refresh();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
